// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control slice: state encoding,
// opcode/funct values, ALU-control codes and datapath mux encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ERROR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct -> ALU control decode.
// Ports:
//   funct   in  6        instr[5:0]
//   aluctrl out ALUC_W   ALU operation (add when funct is not recognised)
//   legal   out 1        funct is one of add/sub/and/or/slt
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  logic [5:0]        funct,
  output logic [ALUC_W-1:0] aluctrl,
  output logic              legal
);

  always_comb begin
    aluctrl = ALU_ADD;
    legal   = 1'b1;
    case (funct)
      FN_ADD:  aluctrl = ALU_ADD;
      FN_SUB:  aluctrl = ALU_SUB;
      FN_AND:  aluctrl = ALU_AND;
      FN_OR:   aluctrl = ALU_OR;
      FN_SLT:  aluctrl = ALU_SLT;
      default: legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath (shared ALU, one memory
// port). Decodes opcode/funct, drives mux selects and write enables, and waits
// on mem_ready with a bounded wait counter.
// Ports: clk, rst (async, active-low), opcode, funct, zero, mem_ready in;
//   mem_req, iord, mem_write, ir_write, pc_en, pcsrc, alusrca, alusrcb,
//   aluctrl, regdst, memtoreg, reg_write, instr_done, error out.
// Build option: MIPS_CTRL_BNE_EN adds bne (opcode 0x05) as a branch on ~zero;
//   without it 0x05 is an illegal opcode.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 when memory answers
// DECODE | register read, branch target precomputed into ALUOut
// MEMADR | lw/sw address = rs + imm
// MEMRD  | load data read, wait for mem_ready
// MEMWB  | load data to rt
// MEMWR  | store, mem_write held until mem_ready
// EXEC   | R-type ALU op from funct
// ALUWB  | R-type result to rd
// BRANCH | compare rs/rt, PC <= ALUOut when taken
// ADDIEX | rs + imm
// ADDIWB | addi result to rt
// JUMP   | PC <= jump target
// ERROR  | illegal instruction or memory timeout; left only by reset
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUC_W  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              iord,
  output logic              mem_write,
  output logic              ir_write,
  output logic              pc_en,
  output logic [1:0]        pcsrc,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [ALUC_W-1:0] aluctrl,
  output logic              regdst,
  output logic              memtoreg,
  output logic              reg_write,
  output logic              instr_done,
  output logic              error
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic [ALUC_W-1:0]  alu_fn;
  logic               fn_legal;
  logic               in_mem;
  logic               timed_out;

  mips_alu_decoder #(.ALUC_W(ALUC_W)) u_alu_dec (
    .funct   (funct),
    .aluctrl (alu_fn),
    .legal   (fn_legal)
  );

  assign in_mem    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // mem_ready in the last allowed cycle still completes the access
  assign timed_out = in_mem && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      // every memory state is entered from a different state, so any
      // transition doubles as the clear-on-entry event
      if (state_next != state)
        wait_cnt <= '0;
      else if (in_mem && !mem_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
                else if (timed_out) state_next = S_ERROR;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_next = S_BRANCH;
`endif
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ERROR;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
                else if (timed_out) state_next = S_ERROR;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
                else if (timed_out) state_next = S_ERROR;
      S_EXEC:   state_next = fn_legal ? S_ALUWB : S_ERROR;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      default:  state_next = S_ERROR;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pcsrc      = PCSRC_ALU;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    aluctrl    = ALU_AND;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    error      = 1'b0;
    // outputs are gated by reset so an access in flight drops immediately
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          alusrcb  = SRCB_FOUR;
          aluctrl  = ALU_ADD;
          ir_write = mem_ready;
          pc_en    = mem_ready;
        end
        S_DECODE: begin
          alusrcb = SRCB_IMMSH2;
          aluctrl = ALU_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          aluctrl = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluctrl = alu_fn;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          aluctrl    = ALU_SUB;
          pcsrc      = PCSRC_ALUOUT;
          instr_done = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
          pc_en      = (opcode == OP_BNE) ? ~zero : zero;
`else
          pc_en      = zero;
`endif
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pcsrc      = PCSRC_JUMP;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        S_ERROR: error = 1'b1;
        default: error = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_en;
  logic [1:0] pcsrc, alusrcb;
  logic       alusrca;
  logic [2:0] aluctrl;
  logic       regdst, memtoreg, reg_write, instr_done, error;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .pc_en(pc_en), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluctrl(aluctrl), .regdst(regdst), .memtoreg(memtoreg),
    .reg_write(reg_write), .instr_done(instr_done), .error(error)
  );

  // one expected cycle: inputs to drive plus the outputs the spec requires
  typedef struct {
    bit mr, z;
    bit mem_req, iord, mem_write, ir_write, pc_en;
    bit [1:0] pcsrc;
    bit alusrca;
    bit [1:0] alusrcb;
    bit [2:0] alu;
    bit alu_dc;
    bit regdst, memtoreg, reg_write, done, error;
    string tag;
  } cyc_t;

  cyc_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_vec();
    return {mem_req, iord, mem_write, ir_write, pc_en, pcsrc, alusrca, alusrcb,
            aluctrl, regdst, memtoreg, reg_write, instr_done, error};
  endfunction

  function automatic logic [17:0] exp_vec(input cyc_t c);
    return {c.mem_req, c.iord, c.mem_write, c.ir_write, c.pc_en, c.pcsrc, c.alusrca,
            c.alusrcb, c.alu, c.regdst, c.memtoreg, c.reg_write, c.done, c.error};
  endfunction

  function automatic cyc_t blank(input string tag);
    cyc_t c;
    c.mr = 1'($urandom); c.z = 1'($urandom);
    c.mem_req = 0; c.iord = 0; c.mem_write = 0; c.ir_write = 0; c.pc_en = 0;
    c.pcsrc = 0; c.alusrca = 0; c.alusrcb = 0; c.alu = 0; c.alu_dc = 0;
    c.regdst = 0; c.memtoreg = 0; c.reg_write = 0; c.done = 0; c.error = 0;
    c.tag = tag;
    return c;
  endfunction

  function automatic bit alu_of(input logic [5:0] fn, output logic [2:0] a);
    a = 3'b010;
    case (fn)
      6'h20: a = 3'b010;
      6'h22: a = 3'b110;
      6'h24: a = 3'b000;
      6'h25: a = 3'b001;
      6'h2A: a = 3'b111;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic err_tail();
    cyc_t c;
    for (int i = 0; i < 3; i++) begin
      c = blank("error"); c.error = 1; q.push_back(c);
    end
  endtask

  // memory access: k cycles without ready, then the completing cycle;
  // 16 or more idle cycles time out into ERROR
  task automatic mem_phase(input cyc_t base, input int k, input bit is_fetch,
                           input bit is_store, output bit to);
    cyc_t c;
    int n;
    to = (k >= 16);
    n = to ? 16 : k;
    for (int i = 0; i < n; i++) begin
      c = base; c.mr = 0; q.push_back(c);
    end
    if (to) begin
      err_tail();
      return;
    end
    c = base; c.mr = 1;
    if (is_fetch) begin c.ir_write = 1; c.pc_en = 1; end
    if (is_store) c.done = 1;
    q.push_back(c);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z,
                       input int kf, input int km, output bit ends_err);
    cyc_t c;
    bit to;
    logic [2:0] a;
    ends_err = 0;
    c = blank("fetch"); c.mem_req = 1; c.alusrcb = 2'b01; c.alu = 3'b010;
    mem_phase(c, kf, 1, 0, to);
    if (to) begin ends_err = 1; return; end
    c = blank("decode"); c.alusrcb = 2'b11; c.alu = 3'b010; q.push_back(c);
    case (op)
      6'h23, 6'h2B: begin
        c = blank("memadr"); c.alusrca = 1; c.alusrcb = 2'b10; c.alu = 3'b010;
        q.push_back(c);
        c = blank(op == 6'h23 ? "memrd" : "memwr");
        c.mem_req = 1; c.iord = 1; c.mem_write = (op == 6'h2B);
        mem_phase(c, km, 0, op == 6'h2B, to);
        if (to) begin ends_err = 1; return; end
        if (op == 6'h23) begin
          c = blank("memwb"); c.reg_write = 1; c.memtoreg = 1; c.done = 1;
          q.push_back(c);
        end
      end
      6'h00: begin
        c = blank("exec"); c.alusrca = 1;
        if (alu_of(fn, a)) begin
          c.alu = a; q.push_back(c);
          c = blank("aluwb"); c.reg_write = 1; c.regdst = 1; c.done = 1;
          q.push_back(c);
        end else begin
          c.alu_dc = 1; q.push_back(c);
          err_tail(); ends_err = 1;
        end
      end
      6'h04: begin
        c = blank("beq"); c.z = z; c.alusrca = 1; c.alu = 3'b110; c.pcsrc = 2'b01;
        c.pc_en = z; c.done = 1; q.push_back(c);
      end
      6'h05: begin
`ifdef MIPS_CTRL_BNE_EN
        c = blank("bne"); c.z = z; c.alusrca = 1; c.alu = 3'b110; c.pcsrc = 2'b01;
        c.pc_en = !z; c.done = 1; q.push_back(c);
`else
        err_tail(); ends_err = 1;
`endif
      end
      6'h08: begin
        c = blank("addiex"); c.alusrca = 1; c.alusrcb = 2'b10; c.alu = 3'b010;
        q.push_back(c);
        c = blank("addiwb"); c.reg_write = 1; c.done = 1; q.push_back(c);
      end
      6'h02: begin
        c = blank("jump"); c.pcsrc = 2'b10; c.pc_en = 1; c.done = 1; q.push_back(c);
      end
      default: begin
        err_tail(); ends_err = 1;
      end
    endcase
  endtask

  // called and left at posedge+1
  task automatic run_n(input int n);
    cyc_t c;
    logic [17:0] m;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      mem_ready = c.mr; zero = c.z;
      #1;
      m = c.alu_dc ? 18'h3FF1F : 18'h3FFFF;
      check(c.tag, {14'd0, dut_vec() & m}, {14'd0, exp_vec(c) & m});
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("reset_outputs_zero", {14'd0, dut_vec()}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                          input int kf, input int km);
    bit e;
    opcode = op; funct = fn;
    q.delete();
    build(op, fn, z, kf, km, e);
    run_n(q.size());
    if (e) do_reset();
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 11) == 0) return $urandom_range(14, 16);
    return $urandom_range(0, 3);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e;
    logic [5:0] op, fn;
    rst = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check("por_outputs_zero", {14'd0, dut_vec()}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    do_instr(6'h23, 6'h00, 0, 0, 0);    // lw, no stalls
    do_instr(6'h2B, 6'h00, 0, 0, 3);    // sw, 3 stall cycles
    do_instr(6'h00, 6'h22, 0, 0, 0);    // sub
    do_instr(6'h00, 6'h3F, 0, 0, 0);    // illegal funct
    do_instr(6'h04, 6'h00, 1, 0, 0);    // beq taken
    do_instr(6'h04, 6'h00, 0, 1, 0);    // beq not taken
    do_instr(6'h05, 6'h00, 0, 0, 0);    // bne
    do_instr(6'h08, 6'h00, 0, 0, 0);    // addi
    do_instr(6'h02, 6'h00, 0, 0, 0);    // j
    do_instr(6'h3F, 6'h00, 0, 0, 0);    // illegal opcode
    do_instr(6'h23, 6'h00, 0, 15, 15);  // ready on the last allowed cycle
    do_instr(6'h23, 6'h00, 0, 16, 0);   // fetch timeout
    do_instr(6'h2B, 6'h00, 0, 0, 16);   // store timeout

    // reset in the middle of a store
    opcode = 6'h2B; funct = 6'h00;
    q.delete();
    build(6'h2B, 6'h00, 0, 0, 5, e);
    run_n(4);
    q.delete();
    mem_ready = 1'b0;
    #1;
    check("memwr_before_reset", {30'd0, mem_write, mem_req}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("memwr_reset_drop", {30'd0, mem_write, mem_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("fetch_after_reset", {29'd0, mem_req, iord, error}, 32'd4);
    @(posedge clk); #1;
    do_reset();

    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 9))
        0: op = 6'h23;
        1: op = 6'h2B;
        2, 3: op = 6'h00;
        4: op = 6'h04;
        5: op = 6'h05;
        6: op = 6'h08;
        7: op = 6'h02;
        8: begin
          op = 6'($urandom);
          while (op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B})
            op = 6'($urandom);
        end
        default: op = 6'h00;
      endcase
      case ($urandom_range(0, 9))
        0: fn = 6'($urandom);
        1, 2: fn = 6'h20;
        3, 4: fn = 6'h22;
        5: fn = 6'h24;
        6: fn = 6'h25;
        default: fn = 6'h2A;
      endcase
      do_instr(op, fn, 1'($urandom), rand_wait(), rand_wait());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
